// File: rtl/scan_sequencer.sv
// Scan sequencer: loads 8-bit instructions serially into the control unit,
// strobes update, holds run, captures the returned scan word, services clears.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   host instruction handshake, cmd_data = word
//   clear_req             single-cycle control-unit clear request
//   ctl_data_out          serial bit returned by the control unit
//   ctl_data_in           serial bit sent to the control unit (MSB first)
//   ctl_reset/shift/
//   ctl_update/run        registered, mutually exclusive control strobes
//   scan_out              word shifted out of the control unit
//   busy, done            not-idle flag, one-cycle completion pulse
module scan_sequencer #(
   parameter int RUN_CYCLES = 1,
   parameter int WORD_W     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   input  logic [WORD_W-1:0] cmd_data,
   output logic              cmd_ready,
   input  logic              clear_req,
   input  logic              ctl_data_out,
   output logic              ctl_data_in,
   output logic              ctl_reset,
   output logic              ctl_shift,
   output logic              ctl_update,
   output logic              ctl_run,
   output logic [WORD_W-1:0] scan_out,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [7:0] RUN_LOAD = 8'(RUN_CYCLES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_UPD   = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;

   logic [2:0]        state;
   logic [WORD_W-1:0] cmd_q;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  nxt_idx;
   logic [7:0]        run_cnt;
   logic              clr_pend;
   logic              shift_d1;

   assign cmd_ready = (state == S_IDLE) && !clr_pend;
   assign busy      = (state != S_IDLE);

   // Bit presented on the following shift cycle (MSB-first order).
   assign nxt_idx = LAST_BIT - CNT_W'(1) - bit_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cmd_q       <= '0;
         bit_cnt     <= '0;
         run_cnt     <= '0;
         clr_pend    <= 1'b0;
         ctl_data_in <= 1'b0;
         ctl_reset   <= 1'b0;
         ctl_shift   <= 1'b0;
         ctl_update  <= 1'b0;
         ctl_run     <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         // A clear arriving mid-instruction waits for the next idle cycle.
         if (clear_req && state != S_IDLE && state != S_CLR)
            clr_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (clr_pend || clear_req) begin
                  state     <= S_CLR;
                  ctl_reset <= 1'b1;
               end else if (cmd_valid) begin
                  state       <= S_SHIFT;
                  cmd_q       <= cmd_data;
                  bit_cnt     <= '0;
                  ctl_shift   <= 1'b1;
                  ctl_data_in <= cmd_data[WORD_W-1];
               end
            end
            S_CLR: begin
               ctl_reset <= 1'b0;
               clr_pend  <= 1'b0;
               state     <= S_IDLE;
            end
            S_SHIFT: begin
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  state       <= S_UPD;
                  ctl_shift   <= 1'b0;
                  ctl_update  <= 1'b1;
                  ctl_data_in <= 1'b0;
               end else begin
                  ctl_data_in <= cmd_q[nxt_idx];
               end
            end
            S_UPD: begin
               ctl_update <= 1'b0;
               ctl_run    <= 1'b1;
               run_cnt    <= RUN_LOAD;
               state      <= S_RUN;
            end
            S_RUN: begin
               if (run_cnt == 8'd0) begin
                  ctl_run <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  run_cnt <= run_cnt - 8'd1;
               end
            end
            default: begin
               state       <= S_IDLE;
               ctl_reset   <= 1'b0;
               ctl_shift   <= 1'b0;
               ctl_update  <= 1'b0;
               ctl_run     <= 1'b0;
               ctl_data_in <= 1'b0;
            end
         endcase
      end
   end

   // The control unit answers one cycle after each shift strobe,
   // so capture runs on the delayed shift enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_d1 <= 1'b0;
         scan_out <= '0;
      end else begin
         shift_d1 <= ctl_shift;
         if (state == S_CLR)
            scan_out <= '0;
         else if (shift_d1)
            scan_out <= {scan_out[WORD_W-2:0], ctl_data_out};
      end
   end

endmodule
